// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and helpers for the execute-stage ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_MULT  = 4'd11,
        OP_MULTU = 4'd12,
        OP_DIV   = 4'd13,
        OP_DIVU  = 4'd14,
        OP_RSVD  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } alu_state_e;

    localparam logic [3:0] OP_RESERVED = 4'd15;

    function automatic logic is_signed_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - shift-add multiply / restoring divide datapath on magnitudes
module alu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             load_div,
    input  logic             run_mul,
    input  logic             run_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // hi_q doubles as product upper half / partial remainder; lo_q as multiplier / dividend-quotient
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, m_q};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            count_q <= '0;
        end else if (load) begin
            hi_q    <= '0;
            lo_q    <= load_div ? a_mag : b_mag;
            m_q     <= load_div ? b_mag : a_mag;
            count_q <= CNT_INIT;
        end else if (run_mul || run_div) begin
            if (run_mul) begin
                hi_q <= add_sum[WIDTH:1];
                lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
            end else if (trial[WIDTH]) begin
                hi_q <= shifted[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                hi_q <= trial[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end
            if (count_q != '0) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;
    assign last   = (count_q == '0);

endmodule

// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - registered ALU with iterative mul/div engine, built when ALU_MULDIV_EN is defined
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               Op_valid,
    input  logic [3:0]         Op_code,
    input  logic [WIDTH-1:0]   Operand_a,
    input  logic [WIDTH-1:0]   Operand_b,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               Busy,
    output logic               Result_valid,
    output logic [WIDTH-1:0]   ALU_result,
    output logic               Zero,
    output logic [WIDTH-1:0]   Hi,
    output logic [WIDTH-1:0]   Lo,
    output logic               Div_by_zero
);

    logic             accept;
    logic             div_zero;
    logic             start_iter;
    logic             fix_valid;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH-1:0] simple_result;
    logic [WIDTH-1:0] sc_result;

    assign accept = Op_valid && !Busy;

    always_comb begin
        simple_result = '0;
        case (Op_code)
            OP_ADD:  simple_result = Operand_a + Operand_b;
            OP_SUB:  simple_result = Operand_a - Operand_b;
            OP_AND:  simple_result = Operand_a & Operand_b;
            OP_OR:   simple_result = Operand_a | Operand_b;
            OP_XOR:  simple_result = Operand_a ^ Operand_b;
            OP_NOR:  simple_result = ~(Operand_a | Operand_b);
            OP_SLT:  simple_result = {{(WIDTH-1){1'b0}}, ($signed(Operand_a) < $signed(Operand_b))};
            OP_SLTU: simple_result = {{(WIDTH-1){1'b0}}, (Operand_a < Operand_b)};
            OP_SLL:  simple_result = Operand_b << Shamt;
            OP_SRL:  simple_result = Operand_b >> Shamt;
            OP_SRA:  simple_result = $unsigned($signed(Operand_b) >>> Shamt);
            default: simple_result = '0;
        endcase
    end

    assign sc_result = div_zero ? {WIDTH{1'b1}} : simple_result;

`ifdef ALU_MULDIV_EN
    alu_state_e       state;
    alu_state_e       next_state;
    logic             is_mul_op;
    logic             is_div_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             is_div_q;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic             core_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;

    assign is_mul_op  = (Op_code == OP_MULT) || (Op_code == OP_MULTU);
    assign is_div_op  = (Op_code == OP_DIV)  || (Op_code == OP_DIVU);
    assign div_zero   = is_div_op && (Operand_b == '0);
    assign start_iter = accept && (is_mul_op || (is_div_op && !div_zero));

    assign a_neg = is_signed_muldiv(Op_code) && Operand_a[WIDTH-1];
    assign b_neg = is_signed_muldiv(Op_code) && Operand_b[WIDTH-1];
    assign a_mag = a_neg ? -Operand_a : Operand_a;
    assign b_mag = b_neg ? -Operand_b : Operand_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start_iter) next_state = is_mul_op ? MUL : DIV;
            MUL, DIV: if (core_last) next_state = FIX;
            FIX:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    assign Busy      = (state != IDLE);
    assign fix_valid = (state == FIX);

    alu_iter_core #(.WIDTH(WIDTH)) u_iter_core (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (start_iter),
        .load_div (is_div_op),
        .run_mul  (state == MUL),
        .run_div  (state == DIV),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_hi   (core_hi),
        .acc_lo   (core_lo),
        .last     (core_last)
    );

    // neg_lo_q: product/quotient sign; neg_hi_q: remainder follows the dividend
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
        end else if (start_iter) begin
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            is_div_q <= is_div_op;
        end
    end

    assign prod_fix = neg_lo_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    assign quot_fix = neg_lo_q ? -core_lo : core_lo;
    assign rem_fix  = neg_hi_q ? -core_hi : core_hi;
    assign fix_hi   = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else if (fix_valid) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if (accept) begin
            dbz_q <= div_zero;
            if (div_zero) begin
                hi_q <= Operand_a;
                lo_q <= {WIDTH{1'b1}};
            end
        end
    end

    assign Hi          = hi_q;
    assign Lo          = lo_q;
    assign Div_by_zero = dbz_q;
`else
    assign div_zero    = 1'b0;
    assign start_iter  = 1'b0;
    assign fix_valid   = 1'b0;
    assign fix_lo      = '0;
    assign Busy        = 1'b0;
    assign Hi          = '0;
    assign Lo          = '0;
    assign Div_by_zero = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ALU_result   <= '0;
            Zero         <= 1'b0;
            Result_valid <= 1'b0;
        end else begin
            Result_valid <= 1'b0;
            if (fix_valid) begin
                ALU_result   <= fix_lo;
                Zero         <= (fix_lo == '0);
                Result_valid <= 1'b1;
            end else if (accept && !start_iter) begin
                ALU_result   <= sc_result;
                Zero         <= (sc_result == '0);
                Result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb/tb_alu_muldiv_unit.sv - scoreboard bench for alu_muldiv_unit, both ALU_MULDIV_EN builds
module tb_alu_muldiv_unit;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        Op_valid;
    logic [3:0]  Op_code;
    logic [31:0] Operand_a;
    logic [31:0] Operand_b;
    logic [4:0]  Shamt;
    logic        Busy;
    logic        Result_valid;
    logic [31:0] ALU_result;
    logic        Zero;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Div_by_zero;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          checks = 0;
    int          errors = 0;

    alu_muldiv_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .Op_valid     (Op_valid),
        .Op_code      (Op_code),
        .Operand_a    (Operand_a),
        .Operand_b    (Operand_b),
        .Shamt        (Shamt),
        .Busy         (Busy),
        .Result_valid (Result_valid),
        .ALU_result   (ALU_result),
        .Zero         (Zero),
        .Hi           (Hi),
        .Lo           (Lo),
        .Div_by_zero  (Div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        e.res = '0;
        e.dbz = 1'b0;
        e.lat = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  e.res = a + b;
            4'd1:  e.res = a - b;
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = ~(a | b);
            4'd6:  e.res = {31'b0, ($signed(a) < $signed(b))};
            4'd7:  e.res = {31'b0, (a < b)};
            4'd8:  e.res = b << sh;
            4'd9:  e.res = b >> sh;
            4'd10: e.res = $unsigned($signed(b) >>> sh);
`ifdef ALU_MULDIV_EN
            4'd11: begin
                p = 64'(sa * sb);
                m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; e.lat = 33;
            end
            4'd12: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; e.lat = 33;
            end
            4'd13, 4'd14: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = '1; e.res = '1; e.dbz = 1'b1;
                end else if (op == 4'd13) begin
                    m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); e.res = m_lo; e.lat = 33;
                end else begin
                    m_lo = a / b; m_hi = a % b; e.res = m_lo; e.lat = 33;
                end
            end
`endif
            default: e.res = '0;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input int intrude_at);
        exp_t e;
        int   cycles;
        int   busy_cnt;
        sb_q.push_back(model(op, a, b, sh));
        @(negedge clock);
        check({tag, "_idle_before"}, 64'(Busy), 64'd0);
        Op_code = op; Operand_a = a; Operand_b = b; Shamt = sh; Op_valid = 1'b1;
        @(posedge clock);
        #1;
        Op_valid = 1'b0;
        Operand_a = ~a; Operand_b = ~b;
        cycles = 0;
        busy_cnt = 0;
        while (!Result_valid && cycles < 100) begin
            if (Busy) busy_cnt++;
            if (cycles == intrude_at) begin
                Op_valid = 1'b1; Op_code = OP_ADD; Operand_a = 32'd7; Operand_b = 32'd9;
            end
            if (cycles == intrude_at + 2) Op_valid = 1'b0;
            @(posedge clock);
            #1;
            cycles++;
        end
        Op_valid = 1'b0;
        e = sb_q.pop_front();
        check({tag, "_valid"},   64'(Result_valid), 64'd1);
        check({tag, "_latency"}, 64'(cycles),       64'(e.lat));
        check({tag, "_busy_cyc"},64'(busy_cnt),     64'(e.lat));
        check({tag, "_busy_end"},64'(Busy),         64'd0);
        check({tag, "_result"},  64'(ALU_result),   64'(e.res));
        check({tag, "_zero"},    64'(Zero),         64'(e.res == 32'd0));
        check({tag, "_hi"},      64'(Hi),           64'(e.hi));
        check({tag, "_lo"},      64'(Lo),           64'(e.lo));
        check({tag, "_dbz"},     64'(Div_by_zero),  64'(e.dbz));
        @(posedge clock);
        #1;
        check({tag, "_pulse_end"}, 64'(Result_valid), 64'd0);
        check({tag, "_hold"},      64'(ALU_result),   64'(e.res));
    endtask

    initial begin
        int pulses;
        reset_n = 1'b0;
        Op_valid = 1'b0;
        Op_code = '0;
        Operand_a = '0;
        Operand_b = '0;
        Shamt = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", 64'(ALU_result),   64'd0);
        check("rst_zero",   64'(Zero),         64'd0);
        check("rst_hi",     64'(Hi),           64'd0);
        check("rst_lo",     64'(Lo),           64'd0);
        check("rst_busy",   64'(Busy),         64'd0);
        check("rst_valid",  64'(Result_valid), 64'd0);
        check("rst_dbz",    64'(Div_by_zero),  64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        issue("sub_eq",   OP_SUB,  32'd5,        32'd5,        5'd0,  -1);
        issue("sltu",     OP_SLTU, 32'd1,        32'hFFFFFFFF, 5'd0,  -1);
        issue("slt_neg",  OP_SLT,  32'hFFFFFFFF, 32'd1,        5'd0,  -1);
        issue("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'd2,        5'd0,  -1);
        issue("sra",      OP_SRA,  32'd0,        32'h80000000, 5'd4,  -1);
        issue("srl",      OP_SRL,  32'd0,        32'h80000000, 5'd4,  -1);
        issue("sll31",    OP_SLL,  32'd0,        32'd1,        5'd31, -1);
        issue("nor",      OP_NOR,  32'h0F0F0000, 32'h000000FF, 5'd0,  -1);
        issue("xor",      OP_XOR,  32'hA5A5A5A5, 32'hFFFF0000, 5'd0,  -1);
        issue("rsvd",     OP_RSVD, 32'h12345678, 32'h1,        5'd0,  -1);
        issue("mult",     OP_MULT, 32'hFFFFFFFD, 32'd5,        5'd0,   5);
        issue("divu",     OP_DIVU, 32'd100,      32'd7,        5'd0,  -1);
        issue("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd0,  -1);
        issue("div_min",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd0,  -1);
        issue("multu_max",OP_MULTU,32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  -1);
        issue("and_hold", OP_AND,  32'hF0F0F0F0, 32'h3C3C3C3C, 5'd0,  -1);
        issue("div_zero", OP_DIV,  32'h00001234, 32'd0,        5'd0,  -1);
        issue("add_clr",  OP_ADD,  32'd3,        32'd4,        5'd0,  -1);

        @(negedge clock);
`ifdef ALU_MULDIV_EN
        Op_code = OP_MULTU; Operand_a = 32'd1000; Operand_b = 32'd3000; Op_valid = 1'b1;
`endif
        @(posedge clock);
        #1;
        Op_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
`ifdef ALU_MULDIV_EN
        check("abort_busy_before", 64'(Busy), 64'd1);
`endif
        reset_n = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        check("abort_busy",   64'(Busy),         64'd0);
        check("abort_hi",     64'(Hi),           64'd0);
        check("abort_lo",     64'(Lo),           64'd0);
        check("abort_result", 64'(ALU_result),   64'd0);
        check("abort_valid",  64'(Result_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (Result_valid) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        issue("add_after", OP_ADD, 32'd2, 32'd3, 5'd0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
